// File: rtl/mobo_bus_if.sv
// CPU <-> motherboard memory bus bundle.
// The cpu side drives ctrl/addr/data_out; the responder drives stat/data_in.
interface mobo_bus_if #(
    parameter int width = 32
);
    logic [width-1:0] mobo_ctrl;
    logic [width-1:0] addr;
    logic [width-1:0] data_out;
    logic [width-1:0] mobo_stat;
    logic [width-1:0] data_in;

    modport master (
        output mobo_ctrl, addr, data_out,
        input  mobo_stat, data_in
    );

    modport slave (
        input  mobo_ctrl, addr, data_out,
        output mobo_stat, data_in
    );
endinterface

// File: rtl/mobo_bus_responder.sv
// Motherboard bus responder: word RAM behind a four-phase req/ack handshake.
// Optional MOBO_RESP_STATS_EN adds the resp_count completed-transaction counter.
module mobo_bus_responder #(
    parameter int width       = 32,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    mobo_bus_if.slave  bus
`ifdef MOBO_RESP_STATS_EN
    ,
    output logic [width-1:0] resp_count
`endif
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic             we_q;
    logic [width-1:0] addr_q;
    logic [width-1:0] wdata_q;
    logic [width-1:0] data_in_q;
    logic             ack_q;
    logic             busy_q;
    logic             err_q;

    logic [width-1:0] mem [DEPTH];

    logic             req;
    logic             we;
    logic             addr_err;
    logic             wr_en_d;
    logic [width-1:0] wr_addr_d;
    logic [width-1:0] wr_data_d;
    logic             unused_ctrl;

    assign req         = bus.mobo_ctrl[0];
    assign we          = bus.mobo_ctrl[1];
    assign unused_ctrl = ^bus.mobo_ctrl[width-1:2];
    assign addr_err    = |addr_q[width-1:ADDR_BITS];

    assign bus.mobo_stat = {{(width-3){1'b0}}, err_q, busy_q, ack_q};
    assign bus.data_in   = data_in_q;

    // Write lands on the edge that enters ACK; with no wait states that is
    // the capture edge itself, so the live bus values are used there.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = addr_q;
        wr_data_d = wdata_q;
        if (!rst) begin
            if (state_q == IDLE && req && WAIT_CYCLES == 0) begin
                wr_en_d   = we;
                wr_addr_d = bus.addr;
                wr_data_d = bus.data_out;
            end else if (state_q == WAIT && cnt_q == 8'd1) begin
                wr_en_d = we_q;
            end
        end
        if (|(wr_addr_d >> ADDR_BITS)) begin
            wr_en_d = 1'b0;
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_addr_d[ADDR_BITS-1:0]] <= wr_data_d;
        end
    end

`ifdef MOBO_RESP_STATS_EN
    logic [width-1:0] resp_count_q;
    assign resp_count = resp_count_q;
`endif

    // Handshake FSM with registered ack/busy/err/data_in outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_in_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MOBO_RESP_STATS_EN
            resp_count_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.data_out;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                    if (addr_err) begin
                        err_q     <= 1'b1;
                        data_in_q <= '0;
                    end else if (!we_q) begin
                        data_in_q <= mem[addr_q[ADDR_BITS-1:0]];
                    end
`ifdef MOBO_RESP_STATS_EN
                    resp_count_q <= resp_count_q + 1'b1;
`endif
                end
                DONE: begin
                    if (!req) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mobo_bus_responder.sv
// Bench for mobo_bus_responder: default build (2 wait states) plus a 0-wait copy,
// both checked against a word-array model of the bus protocol.
module tb_mobo_bus_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mobo_bus_if #(.width(32)) bus0 ();
    mobo_bus_if #(.width(32)) bus1 ();

`ifdef MOBO_RESP_STATS_EN
    logic [31:0] rc0;
    logic [31:0] rc1;
`endif

    mobo_bus_responder #(
        .width(32), .ADDR_BITS(8), .WAIT_CYCLES(2)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
`ifdef MOBO_RESP_STATS_EN
        , .resp_count(rc0)
`endif
    );

    mobo_bus_responder #(
        .width(32), .ADDR_BITS(8), .WAIT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
`ifdef MOBO_RESP_STATS_EN
        , .resp_count(rc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-DUT word store, last data_in, ack count.
    logic [31:0] mdl [2][256];
    bit          vld [2][256];
    logic [31:0] exp_din [2];
    int          exp_rc [2];
    int          waits [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int s, bit rq, bit w, logic [31:0] a, logic [31:0] d);
        if (s == 0) begin
            bus0.mobo_ctrl = {30'd0, w, rq};
            bus0.addr      = a;
            bus0.data_out  = d;
        end else begin
            bus1.mobo_ctrl = {30'd0, w, rq};
            bus1.addr      = a;
            bus1.data_out  = d;
        end
    endtask

    function automatic logic [31:0] stat_of(int s);
        return (s == 0) ? bus0.mobo_stat : bus1.mobo_stat;
    endfunction

    function automatic logic [31:0] din_of(int s);
        return (s == 0) ? bus0.data_in : bus1.data_in;
    endfunction

    task automatic check_rc();
`ifdef MOBO_RESP_STATS_EN
        chk("resp_count0", rc0, exp_rc[0]);
        chk("resp_count1", rc1, exp_rc[1]);
`endif
    endtask

    // One full four-phase transaction, holding req `hold` cycles past ack.
    task automatic txn(int s, bit w, logic [31:0] a, logic [31:0] d, int hold);
        int          k;
        logic [31:0] st;
        bit          bad;
        @(negedge clk);
        drive(s, 1'b1, w, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(s, 1'b1, ~w, $urandom(), $urandom());
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            st = stat_of(s);
            if (!st[0]) chk("busy_wait", {31'd0, st[1]}, 32'd1);
        end while (!st[0] && k < 20);
        chk("ack_latency", k, waits[s] + 1);
        bad = (a >> 8) != 0;
        if (bad) exp_din[s] = 32'd0;
        else if (!w) exp_din[s] = mdl[s][a];
        else begin
            mdl[s][a] = d;
            vld[s][a] = 1'b1;
        end
        exp_rc[s]++;
        chk("stat_ack", st, {29'd0, bad, 2'b11});
        chk("data_in", din_of(s), exp_din[s]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("stat_hold", stat_of(s), {29'd0, bad, 2'b10});
        end
        @(negedge clk);
        drive(s, 1'b0, 1'b0, $urandom(), $urandom());
        @(posedge clk);
        #1;
        chk("stat_idle", stat_of(s), {29'd0, bad, 2'b00});
        chk("data_hold", din_of(s), exp_din[s]);
    endtask

    initial begin
        int          s;
        int          r;
        logic [31:0] a;
        checks = 0;
        errors = 0;
        waits[0] = 2;
        waits[1] = 0;
        for (int i = 0; i < 2; i++) begin
            exp_din[i] = 32'd0;
            exp_rc[i]  = 0;
            for (int j = 0; j < 256; j++) vld[i][j] = 1'b0;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stat0", bus0.mobo_stat, 32'd0);
        chk("rst_din0", bus0.data_in, 32'd0);
        chk("rst_stat1", bus1.mobo_stat, 32'd0);
        check_rc();
        @(negedge clk);
        rst = 1'b0;

        txn(0, 1'b1, 32'h05, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h05, 32'h0, 0);
        txn(0, 1'b0, 32'h100, 32'h0, 0);
        txn(0, 1'b1, 32'h105, 32'h11112222, 0);
        txn(0, 1'b0, 32'h05, 32'h0, 5);
        txn(0, 1'b1, 32'h07, 32'hCAFEF00D, 0);

        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h07, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        exp_din[0] = 32'd0;
        exp_din[1] = 32'd0;
        exp_rc[0]  = 0;
        exp_rc[1]  = 0;
        chk("rst_mid_stat", bus0.mobo_stat, 32'd0);
        chk("rst_mid_din", bus0.data_in, 32'd0);
        check_rc();
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 32'h07, 32'h0, 0);

        txn(1, 1'b1, 32'h10, 32'hA5A5_0001, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 1);
        txn(1, 1'b0, 32'h2000_0010, 32'h0, 0);
        check_rc();

        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if (r < 6 && r >= 3 && vld[s][a]) begin
                txn(s, 1'b0, a, 32'h0, int'($urandom_range(0, 2)));
            end else if (r < 6) begin
                txn(s, 1'b1, a, $urandom(), int'($urandom_range(0, 2)));
            end else begin
                a = $urandom();
                a[8 + (r & 1) * 20] = 1'b1;
                txn(s, r[0], a, $urandom(), int'($urandom_range(0, 2)));
            end
        end
        check_rc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
